// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer and the control unit:
// instruction type codes, default per-type hold counts and sequencer states.
package instr_seq_pkg;

    localparam logic [1:0] TYPE_HALT  = 2'b00;
    localparam logic [1:0] TYPE_STD   = 2'b01;
    localparam logic [1:0] TYPE_LOAD  = 2'b10;
    localparam logic [1:0] TYPE_STORE = 2'b11;

    localparam int DEF_STD_CYCLES   = 3;
    localparam int DEF_LOAD_CYCLES  = 4;
    localparam int DEF_STORE_CYCLES = 3;

    localparam int HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_ZERO  = 8'd0;
    localparam logic [HOLD_W-1:0] HOLD_ONE   = 8'd1;
    localparam logic [HOLD_W-1:0] HOLD_TWO   = 8'd2;
    localparam logic [HOLD_W-1:0] HOLD_THREE = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/instr_seq_hold_lut.sv
// Maps an instruction type field to the number of cycles the control unit
// spends on that instruction; the halt type maps to zero.
module hold_lut
    import instr_seq_pkg::*;
#(
    parameter int STD_CYCLES   = DEF_STD_CYCLES,
    parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES,
    parameter int STORE_CYCLES = DEF_STORE_CYCLES
) (
    input  logic [1:0]        itype,
    output logic [HOLD_W-1:0] cycles
);

    // Type-to-dwell lookup
    always_comb begin
        cycles = HOLD_ZERO;
        case (itype)
            TYPE_STD:   cycles = HOLD_W'(STD_CYCLES);
            TYPE_LOAD:  cycles = HOLD_W'(LOAD_CYCLES);
            TYPE_STORE: cycles = HOLD_W'(STORE_CYCLES);
            default:    cycles = HOLD_ZERO;
        endcase
    end

endmodule

// File: rtl/instr_seq.sv
// Instruction fetch sequencer: holds each word on instr for its type's dwell,
// prefetching the next word so successive instructions follow with no bubble.
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter int INSTR_WIDTH  = 20,
    parameter int IADDR_BITS   = 5,
    parameter int STD_CYCLES   = DEF_STD_CYCLES,
    parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES,
    parameter int STORE_CYCLES = DEF_STORE_CYCLES,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   imem_rd_en,
    output logic [IADDR_BITS-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [IADDR_BITS-1:0]  pc,
    output logic                   busy,
    output logic                   halted,
    output logic                   pc_wrap,
    output logic [CNT_WIDTH-1:0]   retired
);

    // The prefetch fires two cycles before the end of a dwell, so a shorter
    // dwell would leave no room for the memory latency.
    if (STD_CYCLES < 2 || LOAD_CYCLES < 2 || STORE_CYCLES < 2) begin : g_bad_hold
        $error("instr_seq: every hold cycle count must be at least 2");
    end

    seq_state_e             state;
    logic [HOLD_W-1:0]      cnt;
    logic [1:0]             data_type;
    logic [HOLD_W-1:0]      data_hold;
    logic [IADDR_BITS-1:0]  pc_inc;
    logic [IADDR_BITS-1:0]  pc_inc2;
    logic                   pc_last;
    logic                   pc_inc_last;
    logic [CNT_WIDTH-1:0]   retired_inc;

    assign data_type   = imem_data[INSTR_WIDTH-1 -: 2];
    assign pc_inc      = pc + IADDR_BITS'(1'b1);
    assign pc_inc2     = pc + IADDR_BITS'(2'd2);
    assign pc_last     = (pc == {IADDR_BITS{1'b1}});
    assign pc_inc_last = (pc_inc == {IADDR_BITS{1'b1}});
    assign retired_inc = (&retired) ? retired : retired + CNT_WIDTH'(1'b1);

    hold_lut #(
        .STD_CYCLES  (STD_CYCLES),
        .LOAD_CYCLES (LOAD_CYCLES),
        .STORE_CYCLES(STORE_CYCLES)
    ) u_hold_lut (
        .itype (data_type),
        .cycles(data_hold)
    );

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= HOLD_ZERO;
            instr      <= {INSTR_WIDTH{1'b0}};
            pc         <= {IADDR_BITS{1'b0}};
            imem_rd_en <= 1'b0;
            imem_addr  <= {IADDR_BITS{1'b0}};
            busy       <= 1'b0;
            halted     <= 1'b0;
            pc_wrap    <= 1'b0;
            retired    <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    instr <= {INSTR_WIDTH{1'b0}};
                    if (start) begin
                        state      <= ST_FETCH;
                        pc         <= {IADDR_BITS{1'b0}};
                        pc_wrap    <= 1'b0;
                        imem_rd_en <= 1'b1;
                        imem_addr  <= {IADDR_BITS{1'b0}};
                        busy       <= 1'b1;
                        halted     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    imem_rd_en <= 1'b0;
                    state      <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (data_type == TYPE_HALT) begin
                        instr  <= {INSTR_WIDTH{1'b0}};
                        state  <= ST_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        // Extra cycle covers the control unit's RESET-to-DECODE step
                        instr <= imem_data;
                        cnt   <= data_hold + HOLD_ONE;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_ONE) begin
                        pc      <= pc_inc;
                        retired <= retired_inc;
                        cnt     <= data_hold;
                        if (data_type == TYPE_HALT) begin
                            instr      <= {INSTR_WIDTH{1'b0}};
                            state      <= ST_HALT;
                            busy       <= 1'b0;
                            halted     <= 1'b1;
                            imem_rd_en <= 1'b0;
                        end else if (data_hold == HOLD_TWO) begin
                            // A two-cycle word must prefetch on its very first cycle
                            instr      <= imem_data;
                            imem_rd_en <= 1'b1;
                            imem_addr  <= pc_inc2;
                            if (pc_inc_last) begin
                                pc_wrap <= 1'b1;
                            end
                        end else begin
                            instr      <= imem_data;
                            imem_rd_en <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - HOLD_ONE;
                        if (cnt == HOLD_THREE) begin
                            imem_rd_en <= 1'b1;
                            imem_addr  <= pc_inc;
                            if (pc_last) begin
                                pc_wrap <= 1'b1;
                            end
                        end else begin
                            imem_rd_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    imem_rd_en <= 1'b0;
                    busy       <= 1'b0;
                    halted     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_seq.sv
// Scoreboard bench for instr_seq: a ROM-walking reference model queues the
// expected instruction dwells and fetches; a negedge monitor pops and compares.
module tb_instr_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_rd_en;
    logic [4:0]  imem_addr;
    logic [19:0] imem_data;
    logic [19:0] instr;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;
    logic        pc_wrap;
    logic [7:0]  retired;

    logic [19:0] rom [32];

    typedef struct { logic [19:0] w; logic [4:0] pc; int dwell; } seg_t;
    typedef struct { logic [4:0] addr; logic wrap; } fet_t;
    seg_t sq[$];
    fet_t fq[$];

    int passed = 0;
    int total  = 0;
    int m_retired = 0;
    bit m_wrap = 1'b0;

    bit          seg_open = 1'b0;
    logic [19:0] seg_instr;
    logic [4:0]  seg_pc;
    int          seg_len;

    always #5 clk = ~clk;

    instr_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .pc(pc), .busy(busy), .halted(halted),
        .pc_wrap(pc_wrap), .retired(retired)
    );

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= rom[imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int hold_of(input logic [1:0] t);
        case (t)
            2'b01:   return 3;
            2'b10:   return 4;
            2'b11:   return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [19:0] mk(input logic [1:0] t);
        logic [17:0] low;
        low = 18'($urandom);
        return {t, low};
    endfunction

    // Reference model: walk the ROM from address 0 as a fresh start would
    task automatic plan(input int limit);
        int addr = 0;
        int n = 0;
        bit first = 1'b1;
        m_wrap = 1'b0;
        fq.push_back('{addr: 5'd0, wrap: 1'b0});
        while (rom[addr][19:18] != 2'b00 && n < limit) begin
            sq.push_back('{w: rom[addr], pc: 5'(addr), dwell: hold_of(rom[addr][19:18]) + (first ? 1 : 0)});
            n++;
            if (m_retired < 255) m_retired++;
            addr = (addr + 1) % 32;
            if (addr == 0) m_wrap = 1'b1;
            fq.push_back('{addr: 5'(addr), wrap: m_wrap});
            first = 1'b0;
        end
    endtask

    task automatic close_seg();
        seg_t e;
        if (sq.size() == 0) begin
            check("seg_extra", 32'(sq.size()), 32'd1);
        end else begin
            e = sq.pop_front();
            check("seg_word", 32'(seg_instr), 32'(e.w));
            check("seg_pc", 32'(seg_pc), 32'(e.pc));
            check("seg_dwell", 32'(seg_len), 32'(e.dwell));
        end
    endtask

    // Monitor: fetch strobes, instruction segments and ROM consistency
    always @(negedge clk) begin
        fet_t f;
        if (rst) begin
            seg_open = 1'b0;
        end else begin
            if (imem_rd_en) begin
                if (fq.size() == 0) begin
                    check("fetch_extra", 32'(fq.size()), 32'd1);
                end else begin
                    f = fq.pop_front();
                    check("fetch_addr", 32'(imem_addr), 32'(f.addr));
                    check("fetch_wrap", 32'(pc_wrap), 32'(f.wrap));
                end
            end
            if (instr != 20'd0) begin
                check("instr_vs_rom", 32'(instr), 32'(rom[pc]));
                if (seg_open && instr == seg_instr && pc == seg_pc) begin
                    seg_len++;
                end else begin
                    if (seg_open) close_seg();
                    seg_open = 1'b1;
                    seg_instr = instr;
                    seg_pc = pc;
                    seg_len = 1;
                end
            end else if (seg_open) begin
                close_seg();
                seg_open = 1'b0;
            end
        end
    end

    task automatic run_prog(input bit poke);
        bit done = 1'b0;
        plan(1000);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_strobe", 32'(imem_rd_en), 32'd1);
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (halted) done = 1'b1;
            else if (poke && busy && $urandom_range(0, 7) == 0) start = 1'b1;
        end
        check("halt_reached", 32'(done), 32'd1);
        @(negedge clk);
        check("halted", 32'(halted), 32'd1);
        check("busy_off", 32'(busy), 32'd0);
        check("instr_zero", 32'(instr), 32'd0);
        check("retired", 32'(retired), 32'(m_retired));
        check("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
        check("seg_left", 32'(sq.size()), 32'd0);
        check("fetch_left", 32'(fq.size()), 32'd0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_instr", 32'(instr), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_retired", 32'(retired), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rd_en", 32'(imem_rd_en), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        sq.delete();
        fq.delete();
        m_retired = 0;
    endtask

    initial begin
        int n_rd;
        bit ok;
        for (int i = 0; i < 32; i++) rom[i] = mk(2'b01);
        repeat (2) @(negedge clk);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_wrap", 32'(pc_wrap), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // {std, std, halt}
        rom[0] = mk(2'b01); rom[1] = mk(2'b01); rom[2] = mk(2'b00);
        run_prog(1'b0);

        // {loadR, storeR, std, halt}, restarted from HALT
        rom[0] = mk(2'b10); rom[1] = mk(2'b11); rom[2] = mk(2'b01); rom[3] = mk(2'b00);
        run_prog(1'b0);

        // Random programs with stray start pulses while busy
        for (int r = 0; r < 6; r++) begin
            int hidx;
            hidx = (r == 0) ? 0 : $urandom_range(1, 14);
            for (int i = 0; i < 32; i++) rom[i] = mk(2'($urandom_range(1, 3)));
            rom[hidx] = mk(2'b00);
            run_prog(1'b1);
        end

        // 32 std words, no halt: pc wraps and retired saturates
        for (int i = 0; i < 32; i++) rom[i] = mk(2'b01);
        plan(300);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (retired == 8'd255) ok = 1'b1;
        end
        check("sat_reached", 32'(ok), 32'd1);
        repeat (40) @(negedge clk);
        check("sat_hold", 32'(retired), 32'd255);
        check("sat_wrap", 32'(pc_wrap), 32'd1);
        check("sat_busy", 32'(busy), 32'd1);
        mid_reset();

        // Reset while a loadR at pc 1 is being held
        rom[0] = mk(2'b01); rom[1] = mk(2'b10); rom[2] = mk(2'b01); rom[3] = mk(2'b00);
        plan(1000);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (pc == 5'd1 && instr == rom[1]) ok = 1'b1;
        end
        check("load_hold_seen", 32'(ok), 32'd1);
        check("pre_rst_retired", 32'(retired), 32'd1);
        @(negedge clk);
        mid_reset();
        n_rd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_rd_en) n_rd++;
        end
        check("idle_no_fetch", 32'(n_rd), 32'd0);
        check("idle_halted", 32'(halted), 32'd0);
        check("idle_instr", 32'(instr), 32'd0);

        rom[0] = mk(2'b01); rom[1] = mk(2'b11); rom[2] = mk(2'b00);
        run_prog(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_seq.md
Name: instr_seq

Overview:
- Instruction fetch sequencer that feeds the control unit's 20-bit `instr` input from a synchronous instruction memory.
- Holds each instruction stable for exactly the number of cycles the control unit spends on that instruction type, then presents the next one with no bubble cycles.
- Prefetches the next word during the current instruction, counts retired instructions, and halts on a type-00 word.
- Sits between the instruction ROM and the control unit's `instr` port.

Parameters:
- INSTR_WIDTH, 20, instruction word width; type field is bits [19:18].
- IADDR_BITS, 5, instruction memory address width (32 words).
- STD_CYCLES, 3, hold cycles for a type 01 (std_op) instruction: DECODE, EXECUTE, WRITE_BACK.
- LOAD_CYCLES, 4, hold cycles for a type 10 (loadR) instruction: DECODE, EXECUTE, MEM_ACCESS, WRITE_BACK.
- STORE_CYCLES, 3, hold cycles for a type 11 (storeR) instruction: DECODE, EXECUTE, MEM_ACCESS.
- CNT_WIDTH, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins fetching at address 0.
- imem_rd_en  output  1  instruction memory read strobe.
- imem_addr  output  IADDR_BITS  instruction memory read address.
- imem_data  input  INSTR_WIDTH  read data, valid the cycle after imem_rd_en.
- instr  output  INSTR_WIDTH  registered instruction to the control unit.
- pc  output  IADDR_BITS  address of the instruction currently on `instr`.
- busy  output  1  high in FETCH, LOAD, HOLD.
- halted  output  1  high in HALT.
- pc_wrap  output  1  sticky; set when the prefetch address wraps from 2^IADDR_BITS-1 to 0.
- retired  output  CNT_WIDTH  count of completed instructions, saturating at all-ones.

Behaviour:
- Reset (asynchronous, any state): state IDLE, instr=0, pc=0, imem_rd_en=0, imem_addr=0, busy=0, halted=0, pc_wrap=0, retired=0, hold counter=0.
- States: IDLE, FETCH, LOAD, HOLD, HALT.
- IDLE:
  - Keep instr=0, so the control unit stays in its RESET state.
  - On start: go to FETCH, clear pc and pc_wrap.
- FETCH (1 cycle): imem_rd_en=1, imem_addr=pc. Go to LOAD.
- LOAD (1 cycle):
  - Register imem_data into instr.
  - Set the hold counter from the type field: 01 gives STD_CYCLES, 10 gives LOAD_CYCLES, 11 gives STORE_CYCLES.
  - Add 1 for the first instruction after start, which covers the control unit's RESET-to-DECODE cycle.
  - Type 00: instr is loaded as all-zero and the state goes to HALT.
  - Otherwise go to HOLD.
- HOLD:
  - Decrement the counter every cycle.
  - When counter==2: imem_rd_en=1, imem_addr=pc+1 (mod 2^IADDR_BITS). If pc==2^IADDR_BITS-1, set pc_wrap.
  - When counter==1 (final cycle):
    - On the next edge, instr is loaded from imem_data and pc increments.
    - retired increments, saturating.
    - The counter reloads from the new word's type, with no +1 adjustment.
    - If the new word is type 00: instr is loaded as all-zero and the state goes to HALT.
  - Zero-bubble rule: instr changes exactly once every hold-count cycles.
  - All hold parameters must be ≥2 (elaboration check).
- HALT:
  - instr=0, halted=1.
  - start restarts from pc=0 via FETCH and clears pc_wrap; retired is kept.
- start is ignored in FETCH, LOAD and HOLD.
- retired does not count the halting type-00 word.
- imem_rd_en is high for exactly one cycle per fetch. imem_addr holds its last value when imem_rd_en is low.

Decomposition:
- Shared package: type-field constants (TYPE_HALT=2'b00, TYPE_STD=2'b01, TYPE_LOAD=2'b10, TYPE_STORE=2'b11) and the per-type cycle-count defaults, shared with the control unit.
- Optional sub-module `hold_lut`: combinational mapping from type to hold count; everything else is a single module.

Test Plan:
- Start into a ROM of {std, std, 00}:
  - fetch strobes at cycle 1 and then at each counter==2 point;
  - instr holds word 0 for 4 cycles and word 1 for 3 cycles, then goes to 0;
  - halted=1, retired=2.
- Mixed ROM {loadR, storeR, std, 00}: instr dwell times are 5, 3, 3; pc goes 0, 1, 2; retired=3; no cycle where instr differs from the ROM word at pc.
- ROM of 32 std words with no 00:
  - pc wraps 31 to 0 and pc_wrap=1 at the prefetch of address 0;
  - retired saturates at 255 in a long run (CNT_WIDTH=8).
- rst asserted mid-HOLD during a loadR: instr, pc, retired and busy go to 0 asynchronously; state is IDLE; no imem_rd_en until the next start.
- start pulses during HOLD are ignored (pc sequence unchanged). start in HALT restarts at pc=0, pc_wrap is cleared, and retired continues from its held value.
